// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-PC control and status bundle between the pipeline and pc_gen.
interface pc_gen_if #(parameter int XLEN = 32);
    logic            stall;
    logic            halt_req;
    logic            resume;
    logic            trap_valid;
    logic [XLEN-1:0] trap_pc;
    logic            mret_valid;
    logic            br_valid;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] br_pc;
    logic            inst_is_16;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic [XLEN-1:0] pc_next_seq;
    logic [XLEN-1:0] epc;
    logic            misalign_err;
    logic [XLEN-1:0] misalign_addr;
    modport master (
        output stall, halt_req, resume, trap_valid, trap_pc, mret_valid,
               br_valid, br_target, br_pc, inst_is_16,
        input  pc, pc_valid, pc_next_seq, epc, misalign_err, misalign_addr
    );
    modport slave (
        input  stall, halt_req, resume, trap_valid, trap_pc, mret_valid,
               br_valid, br_target, br_pc, inst_is_16,
        output pc, pc_valid, pc_next_seq, epc, misalign_err, misalign_addr
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: prioritised fetch-PC generator with boot/halt states, EPC and misalign trapping.
// PC_COMPRESSED_EN enables 2-byte increments and 2-byte-aligned branch targets.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100)
) (
    input logic     clk,
    input logic     res,
    pc_gen_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    state_t          state;
    logic [XLEN-1:0] pc, epc, misalign_addr, inc;
    logic            pc_valid, misalign_err, misaligned;
`ifdef PC_COMPRESSED_EN
    assign inc        = bus.inst_is_16 ? XLEN'(2) : XLEN'(4);
    assign misaligned = bus.br_target[0];
`else
    logic unused_inst_is_16;
    assign unused_inst_is_16 = bus.inst_is_16;
    assign inc        = XLEN'(4);
    assign misaligned = |bus.br_target[1:0];
`endif
    assign bus.pc            = pc;
    assign bus.pc_valid      = pc_valid;
    assign bus.pc_next_seq   = pc + inc;
    assign bus.epc           = epc;
    assign bus.misalign_err  = misalign_err;
    assign bus.misalign_addr = misalign_addr;
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state         <= BOOT;
            pc            <= RESET_VEC;
            pc_valid      <= 1'b0;
            epc           <= '0;
            misalign_err  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign_err <= 1'b0;
            if (state == BOOT) begin
                state    <= RUN;
                pc_valid <= 1'b1;
            end else if (state == HALT) begin
                if (bus.trap_valid) begin
                    pc       <= TRAP_VEC;
                    epc      <= bus.trap_pc;
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end else if (bus.resume) begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
            end else begin
                // redirects first, so a stall can never swallow one
                if (bus.trap_valid) begin
                    pc  <= TRAP_VEC;
                    epc <= bus.trap_pc;
                end else if (bus.mret_valid) begin
                    pc <= epc;
                end else if (bus.br_valid && misaligned) begin
                    pc            <= TRAP_VEC;
                    epc           <= bus.br_pc;
                    misalign_addr <= bus.br_target;
                    misalign_err  <= 1'b1;
                end else if (bus.br_valid) begin
                    pc <= bus.br_target;
                end else if (!bus.stall) begin
                    if (bus.halt_req) begin
                        state    <= HALT;
                        pc_valid <= 1'b0;
                    end else begin
                        pc <= pc + inc;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed test-plan scenarios plus randomized traffic against a behavioural PC model.
module tb_pc_gen;
    localparam logic [31:0] RV = 32'h0, TV = 32'h100;
    logic clk = 1'b0, res = 1'b1;
    int n_cmp = 0, n_bad = 0;
    pc_gen_if #(32) bus ();
    pc_gen #(.XLEN(32), .RESET_VEC(RV), .TRAP_VEC(TV)) dut (.clk(clk), .res(res), .bus(bus));
    always #5 clk = ~clk;
    logic [31:0] m_pc, m_epc, m_maddr;
    logic        m_valid, m_err, m_boot, m_halted;
`ifdef PC_COMPRESSED_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif
    function automatic logic [31:0] step_size(logic is16);
        return (COMP && is16) ? 32'd2 : 32'd4;
    endfunction
    function automatic bit bad_target(logic [31:0] t);
        return (t % (COMP ? 2 : 4)) != 0;
    endfunction
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_pc = RV; m_epc = 0; m_maddr = 0; m_valid = 0; m_err = 0; m_boot = 1; m_halted = 0;
    endtask
    task automatic model_step();
        m_err = 0;
        if (m_boot) begin
            m_boot = 0; m_valid = 1;
        end else if (m_halted) begin
            if (bus.trap_valid) begin
                m_pc = TV; m_epc = bus.trap_pc; m_halted = 0; m_valid = 1;
            end else if (bus.resume) begin
                m_halted = 0; m_valid = 1;
            end
        end else if (bus.trap_valid) begin
            m_pc = TV; m_epc = bus.trap_pc;
        end else if (bus.mret_valid) begin
            m_pc = m_epc;
        end else if (bus.br_valid) begin
            if (bad_target(bus.br_target)) begin
                m_pc = TV; m_epc = bus.br_pc; m_maddr = bus.br_target; m_err = 1;
            end else m_pc = bus.br_target;
        end else if (bus.stall) begin
        end else if (bus.halt_req) begin
            m_halted = 1; m_valid = 0;
        end else m_pc = m_pc + step_size(bus.inst_is_16);
    endtask
    task automatic compare_all(string tag);
        check({tag, ".pc"}, bus.pc, m_pc);
        check({tag, ".pc_valid"}, 32'(bus.pc_valid), 32'(m_valid));
        check({tag, ".epc"}, bus.epc, m_epc);
        check({tag, ".err"}, 32'(bus.misalign_err), 32'(m_err));
        check({tag, ".maddr"}, bus.misalign_addr, m_maddr);
        check({tag, ".seq"}, bus.pc_next_seq, m_pc + step_size(bus.inst_is_16));
    endtask
    task automatic tick(string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask
    task automatic idle();
        bus.stall = 0; bus.halt_req = 0; bus.resume = 0; bus.trap_valid = 0; bus.trap_pc = 0;
        bus.mret_valid = 0; bus.br_valid = 0; bus.br_target = 0; bus.br_pc = 0; bus.inst_is_16 = 0;
    endtask
    task automatic branch(logic [31:0] t);
        idle(); bus.br_valid = 1; bus.br_target = t; tick("branch");
    endtask
    initial begin
        idle();
        model_reset();
        #1;
        compare_all("reset");
        @(negedge clk); @(negedge clk);
        res = 0;
        tick("boot");
        check("boot_pc", bus.pc, 32'h0);
        check("boot_valid", 32'(bus.pc_valid), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick("seq");
            check("seq_pc", bus.pc, 32'(4 * i));
        end
        // async reset mid-cycle, away from any edge
        #2 res = 1;
        model_reset();
        #1;
        check("async_pc", bus.pc, 32'h0);
        check("async_valid", 32'(bus.pc_valid), 32'd0);
        @(negedge clk) res = 0;
        tick("boot2");
        bus.trap_valid = 1; bus.trap_pc = 32'h40; bus.br_valid = 1; bus.br_target = 32'h80; bus.stall = 1;
        tick("prio");
        check("prio_pc", bus.pc, 32'h100);
        check("prio_epc", bus.epc, 32'h40);
        idle(); bus.mret_valid = 1;
        tick("mret");
        check("mret_pc", bus.pc, 32'h40);
        branch(32'h20);
        idle(); bus.stall = 1;
        tick("stall1");
        check("stall1_pc", bus.pc, 32'h20);
        bus.br_valid = 1; bus.br_target = 32'h200;
        tick("stall2");
        check("stall_br_pc", bus.pc, 32'h200);
        bus.br_valid = 0;
        tick("stall3");
        check("stall3_pc", bus.pc, 32'h200);
        idle(); bus.br_valid = 1; bus.br_pc = 32'h30; bus.br_target = 32'h202;
        tick("mis");
        check("mis_pc", bus.pc, COMP ? 32'h202 : 32'h100);
        check("mis_err", 32'(bus.misalign_err), COMP ? 32'd0 : 32'd1);
        if (!COMP) begin
            check("mis_epc", bus.epc, 32'h30);
            check("mis_addr", bus.misalign_addr, 32'h202);
        end
        idle();
        tick("mis_after");
        check("mis_err_pulse", 32'(bus.misalign_err), 32'd0);
        branch(32'h50);
        idle(); bus.halt_req = 1;
        tick("halt");
        check("halt_valid", 32'(bus.pc_valid), 32'd0);
        idle(); bus.br_valid = 1; bus.br_target = 32'h300;
        tick("halt_br");
        check("halt_br_pc", bus.pc, 32'h50);
        idle(); bus.resume = 1;
        tick("resume");
        check("resume_valid", 32'(bus.pc_valid), 32'd1);
        check("resume_pc", bus.pc, 32'h50);
        idle();
        tick("post_resume");
        check("post_resume_pc", bus.pc, 32'h54);
        bus.halt_req = 1;
        tick("halt2");
        idle(); bus.trap_valid = 1; bus.trap_pc = 32'h50;
        tick("halt_trap");
        check("halt_trap_pc", bus.pc, 32'h100);
        check("halt_trap_epc", bus.epc, 32'h50);
        branch(32'hFFFF_FFFC);
        idle();
        tick("wrap");
        check("wrap_pc", bus.pc, 32'h0);
        branch(32'h10);
        idle(); bus.inst_is_16 = 1;
        tick("c16");
        check("c16_pc", bus.pc, COMP ? 32'h12 : 32'h14);
        for (int i = 0; i < 1500; i++) begin
            idle();
            bus.trap_valid = ($urandom_range(99) < 5);
            bus.trap_pc    = $urandom;
            bus.mret_valid = ($urandom_range(99) < 6);
            bus.br_valid   = ($urandom_range(99) < 15);
            bus.br_target  = {$urandom_range(255), 8'h0} | 32'($urandom_range(3));
            bus.br_pc      = $urandom;
            bus.stall      = ($urandom_range(99) < 20);
            bus.halt_req   = ($urandom_range(99) < 12);
            bus.resume     = ($urandom_range(99) < 25);
            bus.inst_is_16 = 1'($urandom);
            tick("rand");
            if ($urandom_range(99) == 0) begin
                #2 res = 1;
                model_reset();
                #1;
                compare_all("rand_rst");
                @(negedge clk) res = 0;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
